// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared FSM state and next-pc select encodings for pc_seq
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Ordered lowest to highest priority; rst sits above all of these.
    typedef enum logic [2:0] {
        SEL_ADV  = 3'd0,
        SEL_HOLD = 3'd1,
        SEL_RET  = 3'd2,
        SEL_JUMP = 3'd3,
        SEL_TRAP = 3'd4
    } sel_e;

    function automatic logic is_redirect(input sel_e s);
        return (s == SEL_TRAP) || (s == SEL_JUMP) || (s == SEL_RET);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push while full overwrites the oldest entry
module pc_ras #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [W-1:0]                 i_data,
    output logic [W-1:0]                 o_top,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_top_idx;
    logic          w_empty;
    logic          w_full;

    assign w_top_idx = r_ptr - PW'(1);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign o_top     = r_mem[w_top_idx];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_push && i_pop && !w_empty) begin
            r_mem[w_top_idx] <= i_data;
        end else if (i_push) begin
            // When full, r_ptr already points at the oldest slot.
            r_mem[r_ptr] <= i_data;
            r_ptr        <= r_ptr + PW'(1);
            if (!w_full) begin
                r_count <= r_count + CW'(1);
            end
        end else if (i_pop && !w_empty) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - fetch program-counter sequencer; return-address stack built in with PC_SEQ_RAS_EN
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    RESET_ADDR = '0,
    parameter int unsigned          STEP       = 4,
    parameter int unsigned          RAS_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jump,
    input  logic [ADDR_W-1:0]   jump_addr,
    input  logic                trap,
    input  logic [ADDR_W-1:0]   trap_addr,
    input  logic                hold,
    input  logic                call,
    input  logic                ret,
    input  logic                fetch_ready,
    output logic                fetch_valid,
    output logic [ADDR_W-1:0]   pc_o,
    output logic                ras_miss,
    output logic                misalign
);
    localparam logic [ADDR_W-1:0] STEP_W   = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] LOW_MASK = STEP_W - ADDR_W'(1);

    state_e              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_fetch_valid;
    logic                r_ras_miss;
    logic                r_misalign;
    sel_e                w_sel;
    logic [ADDR_W-1:0]   w_target;
    logic [ADDR_W-1:0]   w_ret_target;
    logic                w_ret_miss;

`ifdef PC_SEQ_RAS_EN
    logic                           w_push;
    logic                           w_pop;
    logic [ADDR_W-1:0]              w_ras_top;
    logic [$clog2(RAS_DEPTH+1)-1:0] w_ras_count;

    assign w_push = call & jump & ~trap;
    assign w_pop  = ret & ~trap;

    pc_ras #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_pc + STEP_W),
        .o_top   (w_ras_top),
        .o_count (w_ras_count)
    );

    assign w_ret_miss   = (w_ras_count == '0);
    assign w_ret_target = w_ret_miss ? jump_addr : w_ras_top;
`else
    logic w_unused_call;

    assign w_unused_call = call;
    assign w_ret_miss    = 1'b0;
    assign w_ret_target  = jump_addr;
`endif

    always_comb begin
        w_sel    = SEL_ADV;
        w_target = jump_addr;
        if (trap) begin
            w_sel    = SEL_TRAP;
            w_target = trap_addr;
        end else if (jump) begin
            w_sel    = SEL_JUMP;
        end else if (ret) begin
            w_sel    = SEL_RET;
            w_target = w_ret_target;
        end else if (hold) begin
            w_sel    = SEL_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_ADDR;
            r_fetch_valid <= 1'b0;
            r_ras_miss    <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            r_ras_miss <= 1'b0;
            r_misalign <= 1'b0;

            case (r_state)
                ST_BOOT: begin
                    r_state       <= ST_RUN;
                    r_fetch_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (hold) begin
                        r_state       <= ST_HOLD;
                        r_fetch_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!hold) begin
                        r_state       <= ST_RUN;
                        r_fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase

            // Redirects win over hold/backpressure; the pending request is dropped.
            if (is_redirect(w_sel)) begin
                r_pc       <= w_target & ~LOW_MASK;
                r_misalign <= |(w_target & LOW_MASK);
                r_ras_miss <= (w_sel == SEL_RET) & w_ret_miss;
            end else if (w_sel == SEL_ADV && r_fetch_valid && fetch_ready) begin
                r_pc <= r_pc + STEP_W;
            end
        end
    end

    assign fetch_valid = r_fetch_valid;
    assign pc_o        = r_pc;
    assign ras_miss    = r_ras_miss;
    assign misalign    = r_misalign;

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - directed self-checking bench for pc_seq (RAS scenarios follow PC_SEQ_RAS_EN)
module tb_pc_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        jump;
    logic [31:0] jump_addr;
    logic        trap;
    logic [31:0] trap_addr;
    logic        hold;
    logic        call;
    logic        ret;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc_o;
    logic        ras_miss;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;

    pc_seq dut (
        .clk         (clk),
        .rst         (rst),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .trap        (trap),
        .trap_addr   (trap_addr),
        .hold        (hold),
        .call        (call),
        .ret         (ret),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .pc_o        (pc_o),
        .ras_miss    (ras_miss),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        jump = 1'b0; trap = 1'b0; call = 1'b0; ret = 1'b0; hold = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear_ctl();
        jump_addr = 32'h0; trap_addr = 32'h0; fetch_ready = 1'b1;
        step(); step();
        n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); end
        n_cmp++; if ({fetch_valid, ras_miss, misalign} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {fetch_valid, ras_miss, misalign}); end
        rst = 1'b0;
        n_cmp++; if ({fetch_valid, pc_o} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL boot_cycle: got fv=%b pc=%h want fv=0 pc=0", fetch_valid, pc_o); end
        step();
        n_cmp++; if ({fetch_valid, pc_o} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL run_first: got fv=%b pc=%h want fv=1 pc=0", fetch_valid, pc_o); end
        step();
        n_cmp++; if (pc_o !== 32'h4) begin n_err++; $display("FAIL seq_4: got %h want %h", pc_o, 32'h4); end
        step();
        n_cmp++; if (pc_o !== 32'h8) begin n_err++; $display("FAIL seq_8: got %h want %h", pc_o, 32'h8); end
    endtask

    task automatic test_backpressure_hold();
        step(); step();
        n_cmp++; if (pc_o !== 32'h10) begin n_err++; $display("FAIL reach_10: got %h want %h", pc_o, 32'h10); end
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if ({fetch_valid, pc_o} !== {1'b1, 32'h10}) begin n_err++; $display("FAIL backpressure_%0d: got fv=%b pc=%h want fv=1 pc=10", i, fetch_valid, pc_o); end
        end
        fetch_ready = 1'b1; hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if ({fetch_valid, pc_o} !== {1'b0, 32'h10}) begin n_err++; $display("FAIL hold_%0d: got fv=%b pc=%h want fv=0 pc=10", i, fetch_valid, pc_o); end
        end
        hold = 1'b0;
        step();
        n_cmp++; if ({fetch_valid, pc_o} !== {1'b1, 32'h10}) begin n_err++; $display("FAIL hold_release: got fv=%b pc=%h want fv=1 pc=10", fetch_valid, pc_o); end
        step();
        n_cmp++; if (pc_o !== 32'h14) begin n_err++; $display("FAIL after_hold: got %h want %h", pc_o, 32'h14); end
    endtask

    task automatic test_priority();
        trap = 1'b1; trap_addr = 32'h100; jump = 1'b1; jump_addr = 32'h200; call = 1'b1; ret = 1'b1; hold = 1'b1;
        step(); clear_ctl();
        n_cmp++; if (pc_o !== 32'h100) begin n_err++; $display("FAIL trap_wins: got %h want %h", pc_o, 32'h100); end
        n_cmp++; if (misalign !== 1'b0) begin n_err++; $display("FAIL trap_misalign: got %b want 0", misalign); end
        // An empty RAS here proves the trap-cycle call did not push.
        ret = 1'b1; jump_addr = 32'h300;
        step(); clear_ctl();
        n_cmp++; if (pc_o !== 32'h300) begin n_err++; $display("FAIL no_push_ret: got %h want %h", pc_o, 32'h300); end
`ifdef PC_SEQ_RAS_EN
        n_cmp++; if (ras_miss !== 1'b1) begin n_err++; $display("FAIL no_push_miss: got %b want 1", ras_miss); end
`else
        n_cmp++; if (ras_miss !== 1'b0) begin n_err++; $display("FAIL no_ras_miss_tied: got %b want 0", ras_miss); end
`endif
        step();
    endtask

    task automatic test_call_ret();
        jump = 1'b1; jump_addr = 32'h40;
        step(); clear_ctl();
        n_cmp++; if (pc_o !== 32'h40) begin n_err++; $display("FAIL jump_40: got %h want %h", pc_o, 32'h40); end
        call = 1'b1; jump = 1'b1; jump_addr = 32'h80;
        step(); clear_ctl();
        n_cmp++; if (pc_o !== 32'h80) begin n_err++; $display("FAIL call_80: got %h want %h", pc_o, 32'h80); end
        step(); step();
        n_cmp++; if (pc_o !== 32'h88) begin n_err++; $display("FAIL callee_run: got %h want %h", pc_o, 32'h88); end
        ret = 1'b1; jump_addr = 32'h300;
        step(); clear_ctl();
`ifdef PC_SEQ_RAS_EN
        n_cmp++; if ({ras_miss, pc_o} !== {1'b0, 32'h44}) begin n_err++; $display("FAIL ret_hit: got miss=%b pc=%h want miss=0 pc=44", ras_miss, pc_o); end
`else
        n_cmp++; if ({ras_miss, pc_o} !== {1'b0, 32'h300}) begin n_err++; $display("FAIL ret_plain: got miss=%b pc=%h want miss=0 pc=300", ras_miss, pc_o); end
`endif
        ret = 1'b1; jump_addr = 32'h300;
        step(); clear_ctl();
`ifdef PC_SEQ_RAS_EN
        n_cmp++; if ({ras_miss, pc_o} !== {1'b1, 32'h300}) begin n_err++; $display("FAIL ret_empty: got miss=%b pc=%h want miss=1 pc=300", ras_miss, pc_o); end
`else
        n_cmp++; if ({ras_miss, pc_o} !== {1'b0, 32'h300}) begin n_err++; $display("FAIL ret_plain2: got miss=%b pc=%h want miss=0 pc=300", ras_miss, pc_o); end
`endif
        step();
        n_cmp++; if ({ras_miss, pc_o} !== {1'b0, 32'h304}) begin n_err++; $display("FAIL miss_once: got miss=%b pc=%h want miss=0 pc=304", ras_miss, pc_o); end
    endtask

    task automatic test_wrap_misalign();
        jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
        step(); clear_ctl();
        n_cmp++; if ({misalign, pc_o} !== {1'b0, 32'hFFFF_FFFC}) begin n_err++; $display("FAIL top_addr: got mis=%b pc=%h want mis=0 pc=fffffffc", misalign, pc_o); end
        step();
        n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL wrap: got %h want %h", pc_o, 32'h0); end
        jump = 1'b1; jump_addr = 32'h103;
        step(); clear_ctl();
        n_cmp++; if ({misalign, pc_o} !== {1'b1, 32'h100}) begin n_err++; $display("FAIL misalign_jump: got mis=%b pc=%h want mis=1 pc=100", misalign, pc_o); end
        step();
        n_cmp++; if ({misalign, pc_o} !== {1'b0, 32'h104}) begin n_err++; $display("FAIL misalign_once: got mis=%b pc=%h want mis=0 pc=104", misalign, pc_o); end
    endtask

    task automatic test_ras_overflow();
`ifdef PC_SEQ_RAS_EN
        logic [31:0] exp_ret [5];
        exp_ret[0] = 32'h2304; exp_ret[1] = 32'h2204; exp_ret[2] = 32'h2104;
        exp_ret[3] = 32'h2004; exp_ret[4] = 32'h500;
        jump = 1'b1; jump_addr = 32'h1000;
        step();
        // Back-to-back calls push 1004, 2004, 2104, 2204, 2304; the first is overwritten.
        call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            jump_addr = 32'h2000 + 32'(i) * 32'h100;
            step();
        end
        clear_ctl();
        n_cmp++; if (pc_o !== 32'h2400) begin n_err++; $display("FAIL calls_done: got %h want %h", pc_o, 32'h2400); end
        ret = 1'b1; jump_addr = 32'h500;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if ({ras_miss, pc_o} !== {(i == 4), exp_ret[i]}) begin n_err++; $display("FAIL overflow_ret_%0d: got miss=%b pc=%h want miss=%b pc=%h", i, ras_miss, pc_o, (i == 4), exp_ret[i]); end
        end
        clear_ctl();
        step();
`else
        jump = 1'b1; call = 1'b1; jump_addr = 32'h2000;
        step(); clear_ctl();
        n_cmp++; if (pc_o !== 32'h2000) begin n_err++; $display("FAIL call_plain: got %h want %h", pc_o, 32'h2000); end
`endif
    endtask

    task automatic test_reset_midop();
        rst = 1'b1; jump = 1'b1; call = 1'b1; trap = 1'b1; trap_addr = 32'h700; jump_addr = 32'h680;
        step(); clear_ctl();
        n_cmp++; if ({fetch_valid, ras_miss, misalign, pc_o} !== {3'b000, 32'h0}) begin n_err++; $display("FAIL midop_reset: got fv=%b miss=%b mis=%b pc=%h want 0 0 0 0", fetch_valid, ras_miss, misalign, pc_o); end
        rst = 1'b0; jump = 1'b1; jump_addr = 32'h600;
        step(); clear_ctl();
        n_cmp++; if ({fetch_valid, pc_o} !== {1'b1, 32'h600}) begin n_err++; $display("FAIL boot_redirect: got fv=%b pc=%h want fv=1 pc=600", fetch_valid, pc_o); end
        ret = 1'b1; jump_addr = 32'h640;
        step(); clear_ctl();
`ifdef PC_SEQ_RAS_EN
        n_cmp++; if ({ras_miss, pc_o} !== {1'b1, 32'h640}) begin n_err++; $display("FAIL ras_cleared: got miss=%b pc=%h want miss=1 pc=640", ras_miss, pc_o); end
`else
        n_cmp++; if ({ras_miss, pc_o} !== {1'b0, 32'h640}) begin n_err++; $display("FAIL ret_after_rst: got miss=%b pc=%h want miss=0 pc=640", ras_miss, pc_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_backpressure_hold();
        test_priority();
        test_call_ret();
        test_wrap_misalign();
        test_ras_overflow();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of pc_o, jump_addr, trap_addr and RAS entries.
REQ-002 SHALL have parameter RESET_ADDR, default 0: first fetch address after reset.
REQ-003 SHALL have parameter STEP, default 4: sequential increment in bytes; a power of two.
REQ-004 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries; a power of two, at least 2.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port jump, input, 1 bit: redirect to jump_addr.
REQ-008 SHALL have port jump_addr, input, ADDR_W bits: jump target.
REQ-009 SHALL have port trap, input, 1 bit: redirect to trap_addr; overrides jump.
REQ-010 SHALL have port trap_addr, input, ADDR_W bits: trap vector.
REQ-011 SHALL have port hold, input, 1 bit: freeze pc_o.
REQ-012 SHALL have port call, input, 1 bit: qualifies jump; push the return address.
REQ-013 SHALL have port ret, input, 1 bit: redirect to the RAS top and pop.
REQ-014 SHALL have port fetch_ready, input, 1 bit: fetch side accepts pc_o.
REQ-015 SHALL have port fetch_valid, output, 1 bit: pc_o is a valid request.
REQ-016 SHALL have port pc_o, output, ADDR_W bits: current fetch address.
REQ-017 SHALL have port ras_miss, output, 1 bit: one-cycle pulse when ret hits an empty RAS.
REQ-018 SHALL have port misalign, output, 1 bit: one-cycle pulse when a redirect target has nonzero low log2(STEP) bits.

Function
REQ-019 SHALL implement FSM states BOOT, RUN and HOLD; the state leaves rst as BOOT.
REQ-020 SHALL hold pc_o=RESET_ADDR and fetch_valid=0 in BOOT for exactly one cycle, then enter RUN.
REQ-021 SHALL drive fetch_valid=1 in RUN and fetch_valid=0 in HOLD.
REQ-022 SHALL enter HOLD from RUN when hold=1, and return to RUN when hold=0.
REQ-023 SHALL keep pc_o unchanged while in HOLD.
REQ-024 SHALL compute next pc with priority: rst > trap > jump (incl. call) > ret > hold > advance.
REQ-025 SHALL advance pc_o by STEP only on a handshake (fetch_valid & fetch_ready & !hold), modulo 2^ADDR_W; all-ones minus STEP+1 wraps to 0.
REQ-026 SHALL keep pc_o unchanged when fetch_valid=1 and fetch_ready=0.
REQ-027 SHALL have trap/jump/ret make pc_o equal the target on the next edge, regardless of fetch_ready or hold; the current request is dropped.
REQ-028 SHALL accept a redirect in BOOT; the redirect target then replaces RESET_ADDR.
REQ-029 SHALL clear the low log2(STEP) bits of every redirect target, and pulse misalign when any of those bits were set.
REQ-030 SHALL ignore call and ret on any cycle where trap=1.

Reset
REQ-031 SHALL on rst=1 at a clock edge set state=BOOT, pc_o=RESET_ADDR, fetch_valid=0, ras_miss=0, misalign=0, RAS pointer=0 and RAS count=0.
REQ-032 SHALL have rst asserted mid-operation override every input, including in-flight redirects and pushes.

Configuration
REQ-033 SHALL compile the RAS in when macro PC_SEQ_RAS_EN is defined.
REQ-034 SHALL, with PC_SEQ_RAS_EN defined, on call&jump push pc_o+STEP.
REQ-035 SHALL, with PC_SEQ_RAS_EN defined, on ret with count>0 redirect to the top entry and pop.
REQ-036 SHALL, with PC_SEQ_RAS_EN defined, on ret with count=0 redirect to jump_addr and pulse ras_miss.
REQ-037 SHALL, with PC_SEQ_RAS_EN defined, on a push while full overwrite the oldest entry (circular) and keep count=RAS_DEPTH.
REQ-038 SHALL, with PC_SEQ_RAS_EN defined, on call and ret in the same cycle replace the top entry (pop then push); count unchanged.
REQ-039 SHALL, without PC_SEQ_RAS_EN, have no RAS storage, treat call as a plain jump modifier, treat ret as a jump to jump_addr, and tie ras_miss to 0.

Structure
REQ-040 SHALL place the FSM state enum and priority-select encodings in shared package pc_seq_pkg.
REQ-041 SHALL implement the RAS as sub-module pc_ras (push, pop, top, count), instantiated only under PC_SEQ_RAS_EN.

Verification
REQ-042 SHALL verify reset release: rst 1->0 -> cycle 1 pc_o=0, fetch_valid=0; cycle 2 fetch_valid=1; with fetch_ready=1, pc_o 0,4,8.
REQ-043 SHALL verify backpressure and hold: fetch_ready=0 for 3 cycles at pc_o=0x10 -> pc_o stays 0x10; hold=1 -> fetch_valid=0, pc_o frozen; hold release -> 0x14 next handshake.
REQ-044 SHALL verify priority: trap=1 (0x100), jump=1 (0x200) and call=1 together -> pc_o=0x100, no RAS push.
REQ-045 SHALL verify call/ret: call+jump at pc_o=0x40 to 0x80 -> pc_o=0x80; ret later -> pc_o=0x44; second ret on empty RAS with jump_addr=0x300 -> pc_o=0x300, ras_miss pulses once.
REQ-046 SHALL verify wrap and misalign: pc_o=0xFFFFFFFC with handshake -> pc_o=0; jump to 0x103 -> pc_o=0x100, misalign pulses.
REQ-047 SHALL verify RAS overflow: 5 calls with RAS_DEPTH=4 then 5 rets -> the first 4 rets return the newest 4 addresses, the 5th pulses ras_miss.
